// File: rtl/fpu_div_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fpu_div_pkg
// Brief   : Shared types, constants and rounding helper for the mantissa divider.
// Rev     : 1.0  initial release
// ============================================================================
package fpu_div_pkg;

    localparam int SINGLE_W = 24;
    localparam int DOUBLE_W = 53;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        ITER = 2'd2,
        RND  = 2'd3
    } div_state_t;

    // Round-to-nearest-even increment from LSB, round and sticky bits.
    function automatic logic rne_inc(input logic l, input logic r, input logic s);
        return r & (s | l);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_div_step.sv
`default_nettype none
// ============================================================================
// Module  : fpu_div_step
// Brief   : One combinational restoring-division step (remainder, divisor ->
//           next remainder, quotient bit).
// Rev     : 1.0  initial release
// ============================================================================
module fpu_div_step #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH+1:0] i_rem,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH+1:0] o_rem,
    output logic             o_q_bit
);

    logic [WIDTH+1:0] w_diff;

    // The remainder stays below 2*divisor, so the top bit is a valid sign.
    assign w_diff  = i_rem - {2'b00, i_divisor};
    assign o_q_bit = ~w_diff[WIDTH+1];
    assign o_rem   = o_q_bit ? {w_diff[WIDTH:0], 1'b0} : {i_rem[WIDTH:0], 1'b0};

endmodule
`default_nettype wire

// File: rtl/fpu_mant_div.sv
`default_nettype none
// ============================================================================
// Module  : fpu_mant_div
// Brief   : Iterative restoring mantissa divider with RNE rounding and hold.
//           Define FPU_DIV_RADIX4_EN for two restoring steps per cycle.
// Rev     : 1.0  initial release
// ============================================================================
module fpu_mant_div
    import fpu_div_pkg::*;
#(
    parameter int WIDTH = SINGLE_W,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fpuhold,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic             exp_adj,
    output logic             inexact,
    output logic             divz
);

`ifdef FPU_DIV_RADIX4_EN
    localparam int c_steps = 2;
`else
    localparam int c_steps = 1;
`endif
    localparam int             c_iters    = (WIDTH + c_steps) / c_steps;
    localparam int             c_qw       = c_iters * c_steps;
    localparam int             c_extra    = c_qw - (WIDTH + 1);
    localparam logic [CNTW-1:0] c_cnt_init = CNTW'(c_iters - 1);

    div_state_t        r_state;
    logic [CNTW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH+1:0]  r_rem;
    logic [c_qw-1:0]   r_q;
    logic              r_adj_pend;
    logic              r_dz_pend;
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_quotient;
    logic              r_exp_adj;
    logic              r_inexact;
    logic              r_divz;

    logic [WIDTH+1:0]  w_rem_next;
    logic [c_steps-1:0] w_q_bits;
    logic              w_l;
    logic              w_r;
    logic              w_s;
    logic              w_surplus;
    logic [WIDTH-1:0]  w_rounded;

`ifdef FPU_DIV_RADIX4_EN
    logic [WIDTH+1:0]  w_rem_mid;
    logic              w_q_hi;
    logic              w_q_lo;

    fpu_div_step #(.WIDTH(WIDTH)) u_step_hi (
        .i_rem     (r_rem),
        .i_divisor (r_b),
        .o_rem     (w_rem_mid),
        .o_q_bit   (w_q_hi)
    );
    fpu_div_step #(.WIDTH(WIDTH)) u_step_lo (
        .i_rem     (w_rem_mid),
        .i_divisor (r_b),
        .o_rem     (w_rem_next),
        .o_q_bit   (w_q_lo)
    );
    assign w_q_bits = {w_q_hi, w_q_lo};
`else
    fpu_div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_divisor (r_b),
        .o_rem     (w_rem_next),
        .o_q_bit   (w_q_bits)
    );
`endif

    // A quotient bit computed beyond the round bit only contributes to sticky.
    generate
        if (c_extra != 0) begin : g_surplus
            assign w_surplus = r_q[0];
        end else begin : g_no_surplus
            assign w_surplus = 1'b0;
        end
    endgenerate

    assign w_r       = r_q[c_extra];
    assign w_l       = r_q[c_extra+1];
    assign w_s       = (r_rem != '0) | w_surplus;
    assign w_rounded = r_q[c_qw-1 -: WIDTH] + WIDTH'(rne_inc(w_l, w_r, w_s));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_adj_pend <= 1'b0;
            r_dz_pend  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_quotient <= '0;
            r_exp_adj  <= 1'b0;
            r_inexact  <= 1'b0;
            r_divz     <= 1'b0;
        end else if (!fpuhold) begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    // A start coinciding with the done pulse is dropped.
                    if (start && !r_done) begin
                        r_a     <= dividend;
                        r_b     <= divisor;
                        r_busy  <= 1'b1;
                        r_state <= PRE;
                    end
                end
                PRE: begin
                    r_q <= '0;
                    if (!r_b[WIDTH-1]) begin
                        r_dz_pend  <= 1'b1;
                        r_adj_pend <= 1'b0;
                        r_state    <= RND;
                    end else begin
                        r_dz_pend <= 1'b0;
                        if (r_a < r_b) begin
                            r_rem      <= {1'b0, r_a, 1'b0};
                            r_adj_pend <= 1'b1;
                        end else begin
                            r_rem      <= {2'b00, r_a};
                            r_adj_pend <= 1'b0;
                        end
                        r_cnt   <= c_cnt_init;
                        r_state <= ITER;
                    end
                end
                ITER: begin
                    r_rem <= w_rem_next;
                    r_q   <= {r_q[c_qw-1-c_steps:0], w_q_bits};
                    if (r_cnt == '0) begin
                        r_state <= RND;
                    end else begin
                        r_cnt <= r_cnt - CNTW'(1);
                    end
                end
                RND: begin
                    r_quotient <= r_dz_pend ? '0 : w_rounded;
                    r_inexact  <= r_dz_pend ? 1'b0 : (w_r | w_s);
                    r_exp_adj  <= r_adj_pend;
                    r_divz     <= r_dz_pend;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign quotient = r_quotient;
    assign exp_adj  = r_exp_adj;
    assign inexact  = r_inexact;
    assign divz     = r_divz;

endmodule
`default_nettype wire

// File: tb/tb_fpu_mant_div.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpu_mant_div
// Brief   : Self-checking bench for fpu_mant_div (single-precision width).
// Rev     : 1.0  initial release
// ============================================================================
module tb_fpu_mant_div;

    localparam int W = 24;
`ifdef FPU_DIV_RADIX4_EN
    localparam int LAT = (W + 2) / 2 + 2;
`else
    localparam int LAT = W + 3;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         fpuhold;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic         exp_adj;
    logic         inexact;
    logic         divz;

    int n_cmp = 0;
    int n_err = 0;

    fpu_mant_div #(.WIDTH(W), .CNTW(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .fpuhold  (fpuhold),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .exp_adj  (exp_adj),
        .inexact  (inexact),
        .divz     (divz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic         adj;
        logic         inx;
        logic         dz;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        if (done) step();
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, output int lat);
        lat = base;
        while (!done && lat < base + 200) begin
            step();
            lat++;
        end
        if (!done) check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    // Reference: exact rational quotient truncated to W+1 bits, then RNE.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic adj,
                           output logic inx, output logic dz);
        longint unsigned num, qf, rm, mant;
        logic rb, sb, lb;
        dz = ~b[W-1];
        if (dz) begin
            q = '0; adj = 1'b0; inx = 1'b0;
            return;
        end
        adj  = (a < b);
        num  = adj ? 64'(a) * 2 : 64'(a);
        qf   = (num << W) / 64'(b);
        rm   = (num << W) % 64'(b);
        rb   = qf[0];
        mant = qf >> 1;
        sb   = (rm != 0);
        lb   = mant[0];
        q    = W'(mant + ((rb && (sb || lb)) ? 1 : 0));
        inx  = rb | sb;
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] eq,
                                input logic eadj, input logic einx, input logic edz);
        check({tag, "_quotient"}, 32'(quotient), 32'(eq));
        check({tag, "_inexact"}, {31'd0, inexact}, {31'd0, einx});
        check({tag, "_divz"}, {31'd0, divz}, {31'd0, edz});
        if (!edz) check({tag, "_exp_adj"}, {31'd0, exp_adj}, {31'd0, eadj});
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   lat;
        int   seen;
        logic [W-1:0] eq;
        logic eadj, einx, edz;

        vecs[0] = '{a: 24'h800000, b: 24'h800000, q: 24'h800000, adj: 1'b0, inx: 1'b0, dz: 1'b0};
        vecs[1] = '{a: 24'h800000, b: 24'hC00000, q: 24'hAAAAAB, adj: 1'b1, inx: 1'b1, dz: 1'b0};
        vecs[2] = '{a: 24'hC00000, b: 24'h800000, q: 24'hC00000, adj: 1'b0, inx: 1'b0, dz: 1'b0};
        vecs[3] = '{a: 24'hABCDEF, b: 24'h000000, q: 24'h000000, adj: 1'b0, inx: 1'b0, dz: 1'b1};
        vecs[4] = '{a: 24'hFFFFFF, b: 24'h800000, q: 24'hFFFFFF, adj: 1'b0, inx: 1'b0, dz: 1'b0};
        vecs[5] = '{a: 24'h800000, b: 24'hFFFFFF, q: 24'h800001, adj: 1'b1, inx: 1'b1, dz: 1'b0};

        reset = 1'b1; fpuhold = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_exp_adj", {31'd0, exp_adj}, 32'd0);
        check("rst_inexact", {31'd0, inexact}, 32'd0);
        check("rst_divz", {31'd0, divz}, 32'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].a, vecs[i].b);
            check("busy_after_start", {31'd0, busy}, 32'd1);
            wait_done(0, lat);
            check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].adj, vecs[i].inx, vecs[i].dz);
            if (vecs[i].dz) check("latency_divz_bound", {31'd0, lat <= LAT}, 32'd1);
            else            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
        end

        // Start during the done pulse is dropped; held one more cycle it is taken.
        launch(24'hC00000, 24'h800000);
        wait_done(0, lat);
        check_result("b2b_first", 24'hC00000, 1'b0, 1'b0, 1'b0);
        start = 1'b1; dividend = 24'h800000; divisor = 24'hC00000;
        step();
        check("b2b_ignored_busy", {31'd0, busy}, 32'd0);
        step();
        start = 1'b0;
        check("b2b_accepted_busy", {31'd0, busy}, 32'd1);
        wait_done(0, lat);
        check("b2b_latency", 32'(lat), 32'(LAT));
        check_result("b2b_second", 24'hAAAAAB, 1'b1, 1'b1, 1'b0);

        // Stall mid-iteration, plus a start pulse while busy.
        ref_div(24'h9ABCDE, 24'hD12345, eq, eadj, einx, edz);
        launch(24'h9ABCDE, 24'hD12345);
        repeat (4) step();
        start = 1'b1; dividend = 24'hFFFFFF; divisor = 24'h800000;
        step();
        start = 1'b0;
        repeat (5) step();
        fpuhold = 1'b1;
        repeat (5) step();
        fpuhold = 1'b0;
        wait_done(15, lat);
        check("hold_latency", 32'(lat), 32'(LAT + 5));
        check_result("hold", eq, eadj, einx, edz);
        fpuhold = 1'b1;
        repeat (3) step();
        check("done_held_under_hold", {31'd0, done}, 32'd1);
        fpuhold = 1'b0;
        step();
        check("done_clears_after_hold", {31'd0, done}, 32'd0);
        seen = 0;
        repeat (40) begin
            step();
            if (done) seen++;
        end
        check("no_second_done", 32'(seen), 32'd0);

        // Reset in the middle of iteration aborts cleanly.
        launch(24'h800000, 24'hFFFFFF);
        repeat (12) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_exp_adj", {31'd0, exp_adj}, 32'd0);
        check("abort_inexact", {31'd0, inexact}, 32'd0);
        check("abort_divz", {31'd0, divz}, 32'd0);
        seen = 0;
        repeat (40) begin
            step();
            if (done) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        launch(vecs[1].a, vecs[1].b);
        wait_done(0, lat);
        check("post_abort_latency", 32'(lat), 32'(LAT));
        check_result("post_abort", vecs[1].q, vecs[1].adj, vecs[1].inx, vecs[1].dz);

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'({1'b1, 23'($urandom)});
            rb = W'({1'b1, 23'($urandom)});
            if ($urandom_range(0, 31) == 0) rb[W-1] = 1'b0;
            ref_div(ra, rb, eq, eadj, einx, edz);
            launch(ra, rb);
            wait_done(0, lat);
            check_result($sformatf("rnd%0d", i), eq, eadj, einx, edz);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
